refill_compressor: RTL

- Line-refill engine between the dual instruction caches (raw icache and compressed icache) and instruction memory.
- On a miss it fetches NUM_BLOCKS 32-bit words in order and looks each word up in the three field dictionaries.
- It then fills exactly one cache: compressed keys if every word of the line hit all three dictionaries and compression is enabled, otherwise raw words.
- Replaces the ad-hoc miss logic in the fetch controller with a clean FSM, a flush path and saturating statistics.

---
 rtl/refill_compressor_pkg.sv | 39 +++
 rtl/refill_compressor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/refill_compressor_pkg.sv
// Shared definitions for the instruction-line refill/compression engine.
// Holds the dictionary field value widths, the instruction field slicing
// helpers (also used by the decompression path), their inverse, and the
// refill FSM state type.
package refill_compressor_pkg;

    localparam int unsigned FIELD1_VAL_WIDTH = 7;
    localparam int unsigned FIELD2_VAL_WIDTH = 15;
    localparam int unsigned FIELD3_VAL_WIDTH = 10;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFill
    } state_e;

    // Field 1: opcode bits.
    function automatic logic [FIELD1_VAL_WIDTH-1:0] val_slice1(input logic [31:0] word);
        return word[6:0];
    endfunction

    // Field 2: register specifiers {rs2, rs1, rd}.
    function automatic logic [FIELD2_VAL_WIDTH-1:0] val_slice2(input logic [31:0] word);
        return {word[24:15], word[11:7]};
    endfunction

    // Field 3: function codes {funct7, funct3}.
    function automatic logic [FIELD3_VAL_WIDTH-1:0] val_slice3(input logic [31:0] word);
        return {word[31:25], word[14:12]};
    endfunction

    // Inverse of the three slices: rebuilds the original 32-bit word.
    function automatic logic [31:0] decompress(input logic [FIELD1_VAL_WIDTH-1:0] v1,
                                               input logic [FIELD2_VAL_WIDTH-1:0] v2,
                                               input logic [FIELD3_VAL_WIDTH-1:0] v3);
        return {v3[9:3], v2[14:5], v3[2:0], v2[4:0], v1};
    endfunction

endpackage

// File: rtl/refill_compressor.sv
// Line refill engine feeding the raw and compressed instruction caches.
// On a miss it reads NUM_BLOCKS words of the line in ascending order, looks
// each word up in three external field dictionaries, and fills exactly one
// cache: the compressed one when compression was enabled at miss accept and
// every word hit all three dictionaries, the raw one otherwise.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   comp_enable                 allow a compressed fill (sampled at miss accept)
//   flush                       discard the line currently in flight
//   miss_valid/ready/addr       miss request handshake and byte address
//   mem_req_*                   word read port; data valid when mem_req_ready=1
//   field*_val_lookup           dictionary lookup values sliced from read data
//   field*_val_lookup_result    dictionary hit flags (same cycle)
//   field*_key_out              dictionary keys for the looked-up values
//   raw_fill_*                  raw line fill handshake, address and data
//   comp_fill_*                 compressed line fill handshake, address and keys
//   stat_comp_lines/raw_lines   saturating completed-fill counters
module refill_compressor
    import refill_compressor_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS       = 4,
    parameter int unsigned FIELD1_KEY_WIDTH = 3,
    parameter int unsigned FIELD2_KEY_WIDTH = 8,
    parameter int unsigned FIELD3_KEY_WIDTH = 5,
    parameter int unsigned STAT_WIDTH       = 16,
    localparam int unsigned KW = FIELD1_KEY_WIDTH + FIELD2_KEY_WIDTH + FIELD3_KEY_WIDTH
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          comp_enable,
    input  logic                          flush,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    input  logic [31:0]                   miss_addr,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [31:0]                   mem_req_addr,
    input  logic [31:0]                   mem_req_rdata,
    output logic [FIELD1_VAL_WIDTH-1:0]   field1_val_lookup,
    output logic [FIELD2_VAL_WIDTH-1:0]   field2_val_lookup,
    output logic [FIELD3_VAL_WIDTH-1:0]   field3_val_lookup,
    input  logic                          field1_val_lookup_result,
    input  logic                          field2_val_lookup_result,
    input  logic                          field3_val_lookup_result,
    input  logic [FIELD1_KEY_WIDTH-1:0]   field1_key_out,
    input  logic [FIELD2_KEY_WIDTH-1:0]   field2_key_out,
    input  logic [FIELD3_KEY_WIDTH-1:0]   field3_key_out,
    output logic                          raw_fill_valid,
    input  logic                          raw_fill_ready,
    output logic [31:0]                   raw_fill_addr,
    output logic [32*NUM_BLOCKS-1:0]      raw_fill_data,
    output logic                          comp_fill_valid,
    input  logic                          comp_fill_ready,
    output logic [31:0]                   comp_fill_addr,
    output logic [KW*NUM_BLOCKS-1:0]      comp_fill_data,
    output logic [STAT_WIDTH-1:0]         stat_comp_lines,
    output logic [STAT_WIDTH-1:0]         stat_raw_lines
);

    localparam int unsigned CNT_W = $clog2(NUM_BLOCKS);
    localparam int unsigned OFF_W = CNT_W + 2;
    localparam logic [31:0] OFF_MASK = 32'(NUM_BLOCKS * 4 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BLOCKS - 1);

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [31:0]                      line_addr_q, line_addr_d;
    logic                             compressible_q, compressible_d;
    logic                             flush_pending_q, flush_pending_d;
    logic [STAT_WIDTH-1:0]            stat_comp_q, stat_comp_d;
    logic [STAT_WIDTH-1:0]            stat_raw_q, stat_raw_d;
    logic [NUM_BLOCKS-1:0][31:0]      raw_buf_q;
    logic [NUM_BLOCKS-1:0][KW-1:0]    key_buf_q;

    logic                             buf_we;
    logic                             all_hit;
    logic [KW-1:0]                    key_word;

    assign field1_val_lookup = val_slice1(mem_req_rdata);
    assign field2_val_lookup = val_slice2(mem_req_rdata);
    assign field3_val_lookup = val_slice3(mem_req_rdata);

    assign all_hit  = field1_val_lookup_result & field2_val_lookup_result &
                      field3_val_lookup_result;
    assign key_word = {field3_key_out, field2_key_out, field1_key_out};
    assign buf_we   = (state_q == StFetch) && mem_req_ready;

    assign mem_req_addr    = line_addr_q + {{(32 - OFF_W){1'b0}}, cnt_q, 2'b00};
    assign raw_fill_addr   = line_addr_q;
    assign comp_fill_addr  = line_addr_q;
    assign raw_fill_data   = raw_buf_q;
    assign comp_fill_data  = key_buf_q;
    assign stat_comp_lines = stat_comp_q;
    assign stat_raw_lines  = stat_raw_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        line_addr_d     = line_addr_q;
        compressible_d  = compressible_q;
        flush_pending_d = flush_pending_q;
        stat_comp_d     = stat_comp_q;
        stat_raw_d      = stat_raw_q;
        miss_ready      = 1'b0;
        mem_req_valid   = 1'b0;
        raw_fill_valid  = 1'b0;
        comp_fill_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    line_addr_d     = miss_addr & ~OFF_MASK;
                    cnt_d           = '0;
                    compressible_d  = comp_enable;
                    flush_pending_d = 1'b0;
                    state_d         = StFetch;
                end
            end

            StFetch: begin
                mem_req_valid = 1'b1;
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (mem_req_ready) begin
                    compressible_d = compressible_q & all_hit;
                    if (cnt_q == LAST_CNT) begin
                        // A flush seen on the final beat still discards the line.
                        state_d = (flush_pending_q || flush) ? StIdle : StFill;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            StFill: begin
                comp_fill_valid = compressible_q;
                raw_fill_valid  = ~compressible_q;
                if (flush) begin
                    state_d = StIdle;
                end else if (compressible_q && comp_fill_ready) begin
                    state_d = StIdle;
                    if (stat_comp_q != '1) begin
                        stat_comp_d = stat_comp_q + STAT_WIDTH'(1);
                    end
                end else if (!compressible_q && raw_fill_ready) begin
                    state_d = StIdle;
                    if (stat_raw_q != '1) begin
                        stat_raw_d = stat_raw_q + STAT_WIDTH'(1);
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            line_addr_q     <= '0;
            compressible_q  <= 1'b0;
            flush_pending_q <= 1'b0;
            stat_comp_q     <= '0;
            stat_raw_q      <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            line_addr_q     <= line_addr_d;
            compressible_q  <= compressible_d;
            flush_pending_q <= flush_pending_d;
            stat_comp_q     <= stat_comp_d;
            stat_raw_q      <= stat_raw_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            raw_buf_q <= '0;
            key_buf_q <= '0;
        end else if (buf_we) begin
            raw_buf_q[cnt_q] <= mem_req_rdata;
            key_buf_q[cnt_q] <= key_word;
        end
    end

endmodule
